multicycle_control: RTL and testbench

//  Sequential control unit for the multi-cycle Ak-16b core. It replaces the single-cycle

---
 rtl/multicycle_control.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the Ak-16b core: per-state datapath strobes,
// memory wait/timeout handling, sticky HALT/FAULT and a retired-instruction counter.
//
// state  | meaning
// RST    | held in reset, everything quiet
// FETCH  | read instruction at PC, wait for mem_ready, load IR and PC+1
// DECODE | latch opcode, retire NOP/HALT, trap illegal codes
// EXEC   | ALU operation, branch/jump resolution
// MEM    | data access at ALU result address
// WB     | register file write (ALU result or load data)
// HALT   | absorbing, halted=1
// FAULT  | absorbing, fault=1 (illegal opcode or memory timeout)
module multicycle_control #(
   parameter int OPCODE_W    = 4,
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                is_nop,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                ir_write,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                alu_src,
   output logic                reg_write,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                halted,
   output logic                fault,
   output logic [CNT_W-1:0]    retired_cnt
);

   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
   } state_e;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JUMP, OP_HALT
   } op_e;

   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]    retired_cnt_q, retired_cnt_d;
   logic                retire;
   logic                illegal;
   logic                timeout;

   // Only the low four bits carry a defined instruction; anything above is a trap.
   assign illegal = |(opcode >> 4);
   assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_V) && !mem_ready;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      retire     = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      alu_op     = ALU_ADD;
      halted     = 1'b0;
      fault      = 1'b0;
      case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            op_d = op_e'(opcode[3:0]);
            if (is_nop) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (illegal) begin
               state_d = S_FAULT;
            end else if (op_e'(opcode[3:0]) == OP_HALT) begin
               retire  = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_WB;
            case (op_q)
               OP_ADD:  alu_op = ALU_ADD;
               OP_SUB:  alu_op = ALU_SUB;
               OP_AND:  alu_op = ALU_AND;
               OP_OR:   alu_op = ALU_OR;
               OP_XOR:  alu_op = ALU_XOR;
               OP_SLT:  alu_op = ALU_SLT;
               OP_ADDI: begin alu_op = ALU_ADD; alu_src = 1'b1; end
               OP_ANDI: begin alu_op = ALU_AND; alu_src = 1'b1; end
               OP_ORI:  begin alu_op = ALU_OR;  alu_src = 1'b1; end
               OP_XORI: begin alu_op = ALU_XOR; alu_src = 1'b1; end
               OP_LW, OP_SW: begin
                  alu_src = 1'b1;
                  state_d = S_MEM;
               end
               OP_BEQ, OP_BNE: begin
                  alu_op   = ALU_SUB;
                  pc_src   = 2'd1;
                  pc_write = (op_q == OP_BEQ) ? zero : !zero;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_JUMP: begin
                  pc_write = 1'b1;
                  pc_src   = 2'd2;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
               default: state_d = S_FAULT; // HALT never reaches EXEC
            endcase
         end
         S_MEM: begin
            iord      = 1'b1;
            mem_read  = (op_q == OP_LW);
            mem_write = (op_q == OP_SW);
            if (mem_ready) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (timeout) begin
               state_d = S_FAULT;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_q == OP_LW);
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: state_d = S_FAULT;
      endcase
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
         wait_cnt_d = '0;
      end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      retired_cnt_d = retired_cnt_q + CNT_W'(retire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_RST;
         op_q          <= OP_ADD;
         wait_cnt_q    <= '0;
         retired_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         wait_cnt_q    <= wait_cnt_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction vector table with a retire scoreboard,
// plus hand sequences for timeout, illegal opcode, HALT, mid-access reset and counter wrap.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] opcode;
   logic       is_nop, zero, mem_ready;
   logic       pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
   logic [1:0] pc_src;
   logic [3:0] alu_op;
   logic       halted, fault;
   logic [2:0] retired_cnt;

   int checks   = 0;
   int failures = 0;

   multicycle_control #(
      .OPCODE_W(5), .ALUOP_W(4), .MEM_TIMEOUT(4), .CNT_W(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .is_nop(is_nop), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op), .halted(halted),
      .fault(fault), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] op; logic nop; logic z; int fw; int mw;
      int cycles; int pcw; int pcs; int alu; int src; int regw; int m2r; int memc;
   } vec_t;

   typedef struct {
      int cycles; int pcw; int pcs; int alu; int src; int regw; int m2r; int memc; int tmo;
   } res_t;

   typedef struct { vec_t v; int ret; } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   model_ret;

   function automatic vec_t mk(input int op, nop, z, fw, mw, cycles, pcw, pcs, alu, src,
                               regw, m2r, memc);
      vec_t v;
      v.op = 5'(op); v.nop = nop[0]; v.z = z[0]; v.fw = fw; v.mw = mw;
      v.cycles = cycles; v.pcw = pcw; v.pcs = pcs; v.alu = alu; v.src = src;
      v.regw = regw; v.m2r = m2r; v.memc = memc;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Leaves the bench just after a falling edge with the DUT in FETCH.
   task automatic do_reset();
      rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; is_nop = 1'b0; zero = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_ret = 0;
   endtask

   // Memory model: stalls fetch for fw cycles and the data access for mw cycles.
   task automatic run_instr(input vec_t v, output res_t r);
      int cyc, fseen, mseen;
      logic [2:0] prev;
      bit done;
      r = '{default: 0};
      cyc = 0; fseen = 0; mseen = 0; done = 1'b0;
      prev = retired_cnt;
      opcode = v.op; is_nop = v.nop; zero = v.z;
      while (!done && cyc < 40) begin
         mem_ready = 1'b1;
         #1;
         if (mem_read && !iord) begin
            mem_ready = (fseen >= v.fw);
            fseen++;
         end else if (iord && (mem_read || mem_write)) begin
            mem_ready = (mseen >= v.mw);
            mseen++;
            r.memc++;
         end
         #1;
         if (cyc == v.fw + 2) begin
            r.pcw = pc_write; r.pcs = pc_src; r.alu = alu_op; r.src = alu_src;
         end
         if (reg_write) begin
            r.regw++;
            r.m2r = mem_to_reg;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (retired_cnt != prev || fault || halted) done = 1'b1;
         @(negedge clk);
      end
      r.cycles = cyc;
      r.tmo = !done;
   endtask

   task automatic issue(input vec_t v, input string tag);
      sb_t  e;
      res_t r;
      e.v = v;
      model_ret = (model_ret + 1) % 8;
      e.ret = model_ret;
      sb_q.push_back(e);
      run_instr(v, r);
      e = sb_q.pop_front();
      chk({tag, " timeout"}, r.tmo, 0);
      chk({tag, " cycles"}, r.cycles, e.v.cycles);
      chk({tag, " exec_pc_write"}, r.pcw, e.v.pcw);
      chk({tag, " exec_pc_src"}, r.pcs, e.v.pcs);
      chk({tag, " exec_alu_op"}, r.alu, e.v.alu);
      chk({tag, " exec_alu_src"}, r.src, e.v.src);
      chk({tag, " reg_write_cycles"}, r.regw, e.v.regw);
      chk({tag, " mem_to_reg"}, r.m2r, e.v.m2r);
      chk({tag, " data_mem_cycles"}, r.memc, e.v.memc);
      chk({tag, " retired_cnt"}, retired_cnt, e.ret);
      chk({tag, " fault"}, fault, 0);
   endtask

   initial begin
      int first, bad, hcount;
      // op nop z fw mw | cycles pcw pcs alu src regw m2r memc
      vecs.push_back(mk(0,  0, 0, 0, 0,  4, 0, 0, 0, 0, 1, 0, 0));  // ADD
      vecs.push_back(mk(1,  0, 0, 2, 0,  6, 0, 0, 1, 0, 1, 0, 0));  // SUB, fetch stalls
      vecs.push_back(mk(2,  0, 0, 0, 0,  4, 0, 0, 2, 0, 1, 0, 0));  // AND
      vecs.push_back(mk(3,  0, 0, 0, 0,  4, 0, 0, 3, 0, 1, 0, 0));  // OR
      vecs.push_back(mk(4,  0, 0, 0, 0,  4, 0, 0, 4, 0, 1, 0, 0));  // XOR
      vecs.push_back(mk(5,  0, 0, 0, 0,  4, 0, 0, 5, 0, 1, 0, 0));  // SLT
      vecs.push_back(mk(6,  0, 0, 0, 0,  4, 0, 0, 0, 1, 1, 0, 0));  // ADDI
      vecs.push_back(mk(7,  0, 0, 0, 0,  4, 0, 0, 2, 1, 1, 0, 0));  // ANDI
      vecs.push_back(mk(8,  0, 0, 0, 0,  4, 0, 0, 3, 1, 1, 0, 0));  // ORI
      vecs.push_back(mk(9,  0, 0, 0, 0,  4, 0, 0, 4, 1, 1, 0, 0));  // XORI
      vecs.push_back(mk(10, 0, 0, 0, 3,  8, 0, 0, 0, 1, 1, 1, 4));  // LW, 3 waits
      vecs.push_back(mk(10, 0, 0, 0, 0,  5, 0, 0, 0, 1, 1, 1, 1));  // LW
      vecs.push_back(mk(10, 0, 0, 0, 4,  9, 0, 0, 0, 1, 1, 1, 5));  // LW, ready on timeout cycle
      vecs.push_back(mk(11, 0, 0, 0, 0,  4, 0, 0, 0, 1, 0, 0, 1));  // SW
      vecs.push_back(mk(11, 0, 0, 0, 2,  6, 0, 0, 0, 1, 0, 0, 3));  // SW, 2 waits
      vecs.push_back(mk(12, 0, 1, 0, 0,  3, 1, 1, 1, 0, 0, 0, 0));  // BEQ taken
      vecs.push_back(mk(12, 0, 0, 0, 0,  3, 0, 1, 1, 0, 0, 0, 0));  // BEQ not taken
      vecs.push_back(mk(13, 0, 0, 0, 0,  3, 1, 1, 1, 0, 0, 0, 0));  // BNE taken
      vecs.push_back(mk(13, 0, 1, 0, 0,  3, 0, 1, 1, 0, 0, 0, 0));  // BNE not taken
      vecs.push_back(mk(14, 0, 0, 0, 0,  3, 1, 2, 0, 0, 0, 0, 0));  // JUMP
      vecs.push_back(mk(0,  1, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0));  // NOP
      vecs.push_back(mk(0,  0, 0, 4, 0,  8, 0, 0, 0, 0, 1, 0, 0));  // ADD, fetch ready on timeout cycle

      // reset: all outputs low, even with clocks running
      rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; is_nop = 1'b0; zero = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg,
                            alu_src, reg_write, alu_op, halted, fault, retired_cnt}, 0);
      do_reset();
      #1;
      chk("first_fetch_mem_read", mem_read, 1);
      chk("first_fetch_alu_op", alu_op, 0);

      foreach (vecs[i]) issue(vecs[i], $sformatf("vec%0d", i));

      // memory timeout in FETCH
      do_reset();
      mem_ready = 1'b0;
      first = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (fault && first < 0) first = i + 1;
      end
      chk("timeout_cycles", first, 5);
      @(negedge clk);
      mem_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if ({pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg, alu_src,
              reg_write, alu_op} != 0 || !fault) bad++;
         @(negedge clk);
      end
      chk("fault_absorbing", bad, 0);
      chk("fault_retired_frozen", retired_cnt, 0);

      // illegal opcode traps after DECODE, nothing retires
      do_reset();
      opcode = 5'd16; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("illegal_decode_fault", fault, 0);
      @(posedge clk);
      #1;
      chk("illegal_fault", fault, 1);
      chk("illegal_retired", retired_cnt, 0);
      @(negedge clk);

      // HALT retires and is absorbing
      do_reset();
      issue(mk(15, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0), "halt");
      chk("halted", halted, 1);
      mem_ready = 1'b1;
      bad = 0; hcount = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (mem_read) bad++;
         if (halted) hcount++;
         @(negedge clk);
      end
      chk("halt_no_mem_read", bad, 0);
      chk("halt_sticky", hcount, 20);
      chk("halt_retired_frozen", retired_cnt, 1);

      // reset in the middle of a stalled SW access
      do_reset();
      opcode = 5'd11; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("sw_mem_write", mem_write, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_mid_sw_mem_write", mem_write, 0);
      chk("reset_mid_sw_iord", iord, 0);
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("after_reset_fetch", {mem_read, iord}, 2'b10);
      @(negedge clk);
      @(negedge clk);

      // counter wrap over 9 NOPs
      do_reset();
      for (int i = 0; i < 9; i++)
         issue(mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0), $sformatf("nop%0d", i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
